// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// hamming_pkg : shared constants for the Hamming(7,4) encoder/serializer
// Option macro: HAMMING_SECDED_EN (adds overall parity bit, 8-bit frame)
// Revision: 1.0
// ============================================================================
package hamming_pkg;

  localparam int CODE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic logic [3:0] frame_len();
`ifdef HAMMING_SECDED_EN
    return 4'd8;
`else
    return 4'd7;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming74_calc.sv
`default_nettype none
// ============================================================================
// hamming74_calc : combinational Hamming(7,4) codeword generator
// Option macro: HAMMING_SECDED_EN (code[7] = even parity over code[6:0])
// Revision: 1.0
// ============================================================================
module hamming74_calc
  import hamming_pkg::*;
(
  input  logic [3:0]        i_data,
  output logic [CODE_W-1:0] o_code
);

  logic w_p1;
  logic w_p2;
  logic w_p4;
  logic [6:0] w_code7;

  assign w_p1    = i_data[0] ^ i_data[1] ^ i_data[3];
  assign w_p2    = i_data[0] ^ i_data[2] ^ i_data[3];
  assign w_p4    = i_data[1] ^ i_data[2] ^ i_data[3];
  assign w_code7 = {i_data[3], i_data[2], i_data[1], w_p4, i_data[0], w_p2, w_p1};

`ifdef HAMMING_SECDED_EN
  assign o_code = {^w_code7, w_code7};
`else
  assign o_code = {1'b0, w_code7};
`endif

endmodule
`default_nettype wire

// File: rtl/hamming74_encoder_tx.sv
`default_nettype none
// ============================================================================
// hamming74_encoder_tx : Hamming(7,4) encoder with framed serial output
// Option macro: HAMMING_SECDED_EN (8-bit SECDED frame)
// Revision: 1.0
// ============================================================================
module hamming74_encoder_tx
  import hamming_pkg::*;
#(
  parameter int MSB_FIRST  = 0,
  parameter int GAP_CYCLES = 0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [3:0]        data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              tx_bit,
  output logic              tx_frame,
  output logic              tx_start,
  output logic              busy
);

  localparam logic [3:0] C_N        = frame_len();
  localparam logic [2:0] C_LAST     = 3'(C_N - 4'd1);
  localparam logic [3:0] C_GAP_LAST = 4'(GAP_CYCLES - 2);

  logic [1:0]        r_state;
  logic [2:0]        r_bit_cnt;
  logic [3:0]        r_gap_cnt;
  logic [CODE_W-1:0] r_code;
  logic              r_code_valid;
  logic              r_tx_bit;
  logic              r_tx_frame;
  logic              r_tx_start;

  logic [CODE_W-1:0] w_calc_code;
  logic              w_last;
  logic              w_xfer;

  hamming74_calc u_calc (
    .i_data (data),
    .o_code (w_calc_code)
  );

  function automatic logic [2:0] bit_pos(input logic [2:0] k);
    if (MSB_FIRST != 0) return C_LAST - k;
    else                return k;
  endfunction

  assign w_last     = (r_state == ST_SHIFT) && (r_bit_cnt == C_LAST);
  assign data_ready = EN && ((r_state == ST_IDLE) || (w_last && (GAP_CYCLES == 0)));
  assign w_xfer     = data_valid && data_ready;

  // The IDLE cycle before the next acceptance is itself one of the forced idle
  // cycles, so GAP only lasts GAP_CYCLES-1 cycles (and is skipped for 0 or 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_gap_cnt    <= 4'd0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_tx_bit     <= 1'b0;
      r_tx_frame   <= 1'b0;
      r_tx_start   <= 1'b0;
    end else begin
      r_code_valid <= w_xfer;
      r_tx_start   <= w_xfer;
      if (w_xfer) begin
        r_code     <= w_calc_code;
        r_state    <= ST_SHIFT;
        r_bit_cnt  <= 3'd0;
        r_tx_frame <= 1'b1;
        r_tx_bit   <= w_calc_code[bit_pos(3'd0)];
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (w_last) begin
              r_bit_cnt  <= 3'd0;
              r_gap_cnt  <= 4'd0;
              r_tx_frame <= 1'b0;
              r_tx_bit   <= 1'b0;
              r_state    <= (GAP_CYCLES >= 2) ? ST_GAP : ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx_bit  <= r_code[bit_pos(r_bit_cnt + 3'd1)];
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == C_GAP_LAST) begin
              r_gap_cnt <= 4'd0;
              r_state   <= ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 4'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign tx_bit     = r_tx_bit;
  assign tx_frame   = r_tx_frame;
  assign tx_start   = r_tx_start;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hamming74_encoder_tx.sv
`default_nettype none
// ============================================================================
// tb_hamming74_encoder_tx : three encoder variants (LSB-first, MSB-first, gap=3)
// against a queue-based frame model. Honours HAMMING_SECDED_EN.
// Revision: 1.0
// ============================================================================
module tb_hamming74_encoder_tx;

`ifdef HAMMING_SECDED_EN
  localparam int         N        = 8;
  localparam logic [7:0] C_0111   = 8'hB4;
  localparam logic [7:0] C_1111   = 8'hFF;
  localparam logic       C_MSB1ST = 1'b0;
`else
  localparam int         N        = 7;
  localparam logic [7:0] C_0111   = 8'h34;
  localparam logic [7:0] C_1111   = 8'h7F;
  localparam logic       C_MSB1ST = 1'b1;
`endif
  localparam logic [7:0] C_1000 = 8'h4B;

  typedef struct packed {
    logic frame;
    logic txb;
    logic start;
    logic busy;
  } ent_t;

  logic       clk;
  logic       rst;
  logic       EN;
  logic [3:0] data;
  logic       data_valid;

  logic       o_ready [3];
  logic [7:0] o_code  [3];
  logic       o_cv    [3];
  logic       o_bit   [3];
  logic       o_frame [3];
  logic       o_start [3];
  logic       o_busy  [3];

  hamming74_encoder_tx #(.MSB_FIRST(0), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .EN(EN), .data(data), .data_valid(data_valid),
    .data_ready(o_ready[0]), .code(o_code[0]), .code_valid(o_cv[0]), .tx_bit(o_bit[0]),
    .tx_frame(o_frame[0]), .tx_start(o_start[0]), .busy(o_busy[0]));

  hamming74_encoder_tx #(.MSB_FIRST(1), .GAP_CYCLES(0)) u_dut_msb (
    .clk(clk), .rst(rst), .EN(EN), .data(data), .data_valid(data_valid),
    .data_ready(o_ready[1]), .code(o_code[1]), .code_valid(o_cv[1]), .tx_bit(o_bit[1]),
    .tx_frame(o_frame[1]), .tx_start(o_start[1]), .busy(o_busy[1]));

  hamming74_encoder_tx #(.MSB_FIRST(0), .GAP_CYCLES(3)) u_dut_gap (
    .clk(clk), .rst(rst), .EN(EN), .data(data), .data_valid(data_valid),
    .data_ready(o_ready[2]), .code(o_code[2]), .code_valid(o_cv[2]), .tx_bit(o_bit[2]),
    .tx_frame(o_frame[2]), .tx_start(o_start[2]), .busy(o_busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending output cycles per variant
  int         C_MSB [3] = '{0, 1, 0};
  int         C_GAP [3] = '{0, 0, 3};
  ent_t       m_q   [3][$];
  ent_t       m_cur [3];
  logic [7:0] m_code[3];
  logic       m_cv  [3];

  int frame_run[3], frame_max[3], frame_total[3], low_run[3], last_gap[3];
  int rdy_low[3], last_rdy_low[3];
  bit seen_frame[3];

  // Hamming positions 1..7: data at 3,5,6,7; parity 2^k covers positions with bit k set
  function automatic logic [7:0] ref_code(input logic [3:0] d);
    logic [7:0] c;
    logic       p;
    c = 8'd0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p ^= c[pos-1];
      c[(1 << k) - 1] = p;
    end
    if (N == 8) c[7] = ^c[6:0];
    return c;
  endfunction

  function automatic logic model_ready(input int i, input logic en);
    return en && (m_q[i].size() == 0) &&
           (!m_cur[i].busy || (C_GAP[i] == 0 && m_cur[i].frame));
  endfunction

  task automatic model_reset(input int i);
    m_q[i].delete();
    m_cur[i]  = '0;
    m_code[i] = 8'd0;
    m_cv[i]   = 1'b0;
  endtask

  task automatic model_step(input int i, input logic en, input logic v, input logic [3:0] d);
    ent_t e;
    int   idx;
    if (v && model_ready(i, en)) begin
      m_code[i] = ref_code(d);
      m_cv[i]   = 1'b1;
      for (int k = 0; k < N; k++) begin
        idx = (C_MSB[i] != 0) ? (N - 1 - k) : k;
        e = '{frame: 1'b1, txb: m_code[i][idx], start: (k == 0), busy: 1'b1};
        m_q[i].push_back(e);
      end
      for (int g = 0; g < C_GAP[i] - 1; g++) m_q[i].push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    end else begin
      m_cv[i] = 1'b0;
    end
    m_cur[i] = (m_q[i].size() != 0) ? m_q[i].pop_front() : ent_t'('0);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) begin
      frame_run[i] = 0; frame_max[i] = 0; frame_total[i] = 0; low_run[i] = 0;
      last_gap[i] = -1; rdy_low[i] = 0; last_rdy_low[i] = -1; seen_frame[i] = 0;
    end
  endtask

  task automatic run_cycle(input logic en, input logic v, input logic [3:0] d);
    @(negedge clk);
    EN = en; data_valid = v; data = d;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d data_ready", i), 8'(o_ready[i]), 8'(model_ready(i, en)));
      check_eq($sformatf("u%0d tx_frame", i),   8'(o_frame[i]), 8'(m_cur[i].frame));
      check_eq($sformatf("u%0d tx_bit", i),     8'(o_bit[i]),   8'(m_cur[i].txb));
      check_eq($sformatf("u%0d tx_start", i),   8'(o_start[i]), 8'(m_cur[i].start));
      check_eq($sformatf("u%0d busy", i),       8'(o_busy[i]),  8'(m_cur[i].busy));
      check_eq($sformatf("u%0d code", i),       o_code[i],      m_code[i]);
      check_eq($sformatf("u%0d code_valid", i), 8'(o_cv[i]),    8'(m_cv[i]));
      if (o_frame[i]) begin
        if (seen_frame[i] && low_run[i] > 0) last_gap[i] = low_run[i];
        low_run[i] = 0; seen_frame[i] = 1;
        frame_run[i]++; frame_total[i]++;
        if (frame_run[i] > frame_max[i]) frame_max[i] = frame_run[i];
      end else begin
        frame_run[i] = 0; low_run[i]++;
      end
      if (o_ready[i]) begin
        if (rdy_low[i] > 0) last_rdy_low[i] = rdy_low[i];
        rdy_low[i] = 0;
      end else begin
        rdy_low[i]++;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) model_reset(i);
      else     model_step(i, en, v, d);
    end
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < n; c++) run_cycle(1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; EN = 1'b0; data_valid = 1'b0; data = 4'd0;
    for (int i = 0; i < 3; i++) model_reset(i);
    clear_stats();
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b1, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    drain(2);

    // Single nibble 0111, LSB-first and MSB-first shapes
    run_cycle(1'b1, 1'b1, 4'b0111);
    #1;
    check_eq("code 0111", o_code[0], C_0111);
    check_eq("first bit 0111", 8'(o_bit[0]), 8'd0);
    check_eq("start 0111", 8'(o_start[0]), 8'd1);
    drain(N + 5);

    run_cycle(1'b1, 1'b1, 4'b1000);
    #1;
    check_eq("code 1000", o_code[1], C_1000);
    check_eq("msb first bit 1000", 8'(o_bit[1]), 8'(C_MSB1ST));
    drain(N + 5);

    // Reset during bit 3
    run_cycle(1'b1, 1'b1, 4'b0101);
    for (int c = 0; c < 3; c++) run_cycle(1'b1, 1'b0, 4'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst u%0d frame", i), 8'(o_frame[i]), 8'd0);
      check_eq($sformatf("rst u%0d bit", i),   8'(o_bit[i]),   8'd0);
      check_eq($sformatf("rst u%0d code", i),  o_code[i],      8'd0);
      check_eq($sformatf("rst u%0d busy", i),  8'(o_busy[i]),  8'd0);
      check_eq($sformatf("rst u%0d ready", i), 8'(o_ready[i]), 8'(EN));
      model_reset(i);
    end
    @(negedge clk);
    rst = 1'b0;
    run_cycle(1'b1, 1'b1, 4'b0011);
    drain(N + 5);

    // Back-to-back 0000 then 1111 with valid held
    clear_stats();
    run_cycle(1'b1, 1'b1, 4'b0000);
    for (int c = 0; c < N; c++) run_cycle(1'b1, 1'b1, 4'b1111);
    drain(2 * N + 6);
    check_eq("b2b u0 frame run", 8'(frame_max[0]), 8'(2 * N));
    check_eq("b2b u1 frame run", 8'(frame_max[1]), 8'(2 * N));
    check_eq("b2b u0 final code", o_code[0], C_1111);

    // Continuous valid with GAP_CYCLES=3
    clear_stats();
    for (int c = 0; c < 4 * (N + 3); c++) run_cycle(1'b1, 1'b1, 4'($urandom));
    check_eq("gap idle cycles", 8'(last_gap[2]), 8'd3);
    check_eq("gap ready low", 8'(last_rdy_low[2]), 8'(N - 1 + 3));
    drain(N + 5);

    // EN dropped at bit 2
    clear_stats();
    run_cycle(1'b1, 1'b1, 4'b0110);
    run_cycle(1'b1, 1'b0, 4'd0);
    run_cycle(1'b1, 1'b0, 4'd0);
    for (int c = 0; c < 2 * N + 5; c++) run_cycle(1'b0, 1'b1, 4'($urandom));
    check_eq("en drop u0 bits", 8'(frame_total[0]), 8'(N));
    check_eq("en drop u2 bits", 8'(frame_total[2]), 8'(N));
    drain(3);

    // Randomized traffic
    for (int c = 0; c < 600; c++)
      run_cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0), 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
